pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//   Central stall/flush/exception sequencer for the 5-stage pipeline.
//   Drives WE/flush/req of PC, FD, DE, EM and MW pipeline registers.
//   Tracks the multi-cycle mult/div unit (busy FSM) and counts stall cycles.
//   Sits beside the hazard-detect logic; consumes D-stage hazard flags and the M-stage CP0 request.
// PARAMETERS
//   MULT_LAT  5   cycles mult/multu occupies MDU after start cycle
//   DIV_LAT   10  cycles div/divu occupies MDU after start cycle
//   CNT_W     32  width of stall performance counter
// PORTS
//   clk          in   1      clock, rising edge
//   reset        in   1      synchronous, active-high
//   D_hz_stall   in   1      data-hazard stall request from D-stage forwarding/use check
//   D_is_md      in   1      D instr is mult/div/mfhi/mflo/mthi/mtlo
//   E_md_start   in   1      E instr starts mult/div this cycle
//   E_md_is_div  in   1      qualifies E_md_start: 1=div/divu, 0=mult/multu
//   M_exc_req    in   1      CP0 exception/interrupt taken in M this cycle
//   PC_WE        out  1      PC update enable
//   FD_WE        out  1      FD register write enable
//   DE_WE        out  1      DE register write enable
//   DE_flush     out  1      insert bubble into DE
//   EM_WE        out  1      EM register write enable
//   MW_WE        out  1      MW register write enable
//   req          out  1      to all pipeline regs: load handler PC 0x4180, clear Instr
//   md_busy      out  1      MDU occupied (registered state)
//   md_cnt       out  4      remaining MDU cycles
//   stall_cnt    out  CNT_W  total stall cycles since reset
// BEHAVIOUR
//   Reset (sync): md_cnt=0, md_busy=0, stall_cnt=0, FSM=IDLE.
//   Combinational outputs during reset: all WE=1, DE_flush=0, req=0.
//   stall = ~M_exc_req & (D_hz_stall | (D_is_md & (md_busy | md_go)));
//     md_go = E_md_start & ~M_exc_req.
//   Normal: all WE=1, DE_flush=0.
//   stall=1: PC_WE=0, FD_WE=0, DE_flush=1, DE_WE=1, EM_WE=1, MW_WE=1.
//   req = M_exc_req, zero latency.
//     Overrides stall: all WE=1, DE_flush=0.
//     Pipeline regs give req priority over flush/WE.
//   MDU FSM (IDLE/BUSY), state in md_cnt:
//     IDLE & md_go -> BUSY; md_cnt <= E_md_is_div ? DIV_LAT : MULT_LAT.
//     BUSY: md_cnt decrements by 1 per cycle; md_cnt==1 -> IDLE next edge (md_cnt=0).
//     md_busy = (md_cnt != 0). Busy for exactly LAT cycles after the start edge.
//     E_md_start while BUSY: cannot occur, because D stalls md instrs.
//     If it occurs anyway, ignore it; md_cnt is not reloaded.
//     E_md_start with M_exc_req same cycle: ignored.
//     The E instr is younger than the excepting M instr and must not start.
//     M_exc_req during BUSY: count continues.
//     The owning instr is older and already committed.
//   stall_cnt: +1 on every edge with stall=1; wraps modulo 2^CNT_W; no saturation.
//   Simultaneous D_hz_stall and MDU stall: a single stall cycle, counted once.
//   Reset mid-BUSY: md_cnt=0 next edge; stall drops the following cycle.
// TESTING
//   1. reset 2 cycles -> md_busy=0, stall_cnt=0, all WE=1, req=0, DE_flush=0.
//   2. E_md_start=1, E_md_is_div=0 at cycle t -> md_cnt=5 at t+1, md_busy 1 for t+1..t+5, 0 at t+6.
//   3. div start t, D_is_md=1 held -> PC_WE=FD_WE=0, DE_flush=1 for t..t+10; stall_cnt=11 at t+11.
//   4. E_md_start=1 and M_exc_req=1 same cycle -> md_cnt stays 0, req=1, all WE=1, no stall.
//   5. D_hz_stall=1 with M_exc_req=1 -> req=1, PC_WE=1, DE_flush=0, stall_cnt unchanged.
//   6. force stall_cnt=32'hFFFF_FFFF, one stall cycle -> stall_cnt=0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/exception sequencer for the 5-stage pipeline: pipeline register
// enables, a busy tracker for the multi-cycle mult/div unit, and a stall counter.
module pipe_hazard_ctrl #(
    parameter int unsigned MULT_LAT = 5,
    parameter int unsigned DIV_LAT  = 10,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             D_hz_stall,
    input  logic             D_is_md,
    input  logic             E_md_start,
    input  logic             E_md_is_div,
    input  logic             M_exc_req,
    output logic             PC_WE,
    output logic             FD_WE,
    output logic             DE_WE,
    output logic             DE_flush,
    output logic             EM_WE,
    output logic             MW_WE,
    output logic             req,
    output logic             md_busy,
    output logic [3:0]       md_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [0:0] {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    localparam logic [3:0] MULT_CNT = 4'(MULT_LAT);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_LAT);

    md_state_e        state_q, state_d;
    logic [3:0]       md_cnt_q, md_cnt_d;
    logic             md_busy_q, md_busy_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             md_go_s;
    logic             stall_s;

    // Stall decision; an excepting M instr kills the younger E start, and reset forces a free-running pipe
    always_comb begin
        md_go_s = E_md_start & ~M_exc_req;
        stall_s = ~reset & ~M_exc_req & (D_hz_stall | (D_is_md & (md_busy_q | md_go_s)));
    end

    // MDU occupancy next state; starts seen while busy are ignored and never reload the count
    always_comb begin
        state_d  = state_q;
        md_cnt_d = md_cnt_q;
        case (state_q)
            MD_IDLE: begin
                if (md_go_s) begin
                    state_d  = MD_BUSY;
                    md_cnt_d = E_md_is_div ? DIV_CNT : MULT_CNT;
                end else begin
                    state_d  = MD_IDLE;
                    md_cnt_d = 4'd0;
                end
            end
            MD_BUSY: begin
                md_cnt_d = md_cnt_q - 4'd1;
                if (md_cnt_q == 4'd1) begin
                    state_d = MD_IDLE;
                end else begin
                    state_d = MD_BUSY;
                end
            end
            default: begin
                state_d  = MD_IDLE;
                md_cnt_d = 4'd0;
            end
        endcase
        md_busy_d = (md_cnt_d != 4'd0);
    end

    // Stall performance counter, wraps naturally
    always_comb begin
        if (stall_s) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= MD_IDLE;
            md_cnt_q    <= 4'd0;
            md_busy_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            md_cnt_q    <= md_cnt_d;
            md_busy_q   <= md_busy_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Pipeline register controls; exception request wins over any stall
    always_comb begin
        PC_WE    = 1'b1;
        FD_WE    = 1'b1;
        DE_WE    = 1'b1;
        DE_flush = 1'b0;
        EM_WE    = 1'b1;
        MW_WE    = 1'b1;
        req      = 1'b0;
        if (reset) begin
            req = 1'b0;
        end else if (M_exc_req) begin
            req = 1'b1;
        end else if (stall_s) begin
            PC_WE    = 1'b0;
            FD_WE    = 1'b0;
            DE_flush = 1'b1;
        end else begin
            req = 1'b0;
        end
    end

    assign md_busy   = md_busy_q;
    assign md_cnt    = md_cnt_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl; a second instance with a
// 4-bit counter exercises stall counter wrap-around.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        D_hz_stall, D_is_md, E_md_start, E_md_is_div, M_exc_req;
    logic        PC_WE, FD_WE, DE_WE, DE_flush, EM_WE, MW_WE, req, md_busy;
    logic [3:0]  md_cnt;
    logic [31:0] stall_cnt;

    logic        w_hz;
    logic        w_pc_we, w_fd_we, w_de_we, w_de_flush, w_em_we, w_mw_we, w_req, w_busy;
    logic [3:0]  w_md_cnt;
    logic [3:0]  w_stall_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut (
        .clk(clk), .reset(reset), .D_hz_stall(D_hz_stall), .D_is_md(D_is_md),
        .E_md_start(E_md_start), .E_md_is_div(E_md_is_div), .M_exc_req(M_exc_req),
        .PC_WE(PC_WE), .FD_WE(FD_WE), .DE_WE(DE_WE), .DE_flush(DE_flush),
        .EM_WE(EM_WE), .MW_WE(MW_WE), .req(req), .md_busy(md_busy),
        .md_cnt(md_cnt), .stall_cnt(stall_cnt)
    );

    pipe_hazard_ctrl #(.CNT_W(4)) wrap_dut (
        .clk(clk), .reset(reset), .D_hz_stall(w_hz), .D_is_md(1'b0),
        .E_md_start(1'b0), .E_md_is_div(1'b0), .M_exc_req(1'b0),
        .PC_WE(w_pc_we), .FD_WE(w_fd_we), .DE_WE(w_de_we), .DE_flush(w_de_flush),
        .EM_WE(w_em_we), .MW_WE(w_mw_we), .req(w_req), .md_busy(w_busy),
        .md_cnt(w_md_cnt), .stall_cnt(w_stall_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        D_hz_stall  = 1'b0;
        D_is_md     = 1'b0;
        E_md_start  = 1'b0;
        E_md_is_div = 1'b0;
        M_exc_req   = 1'b0;
        w_hz        = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    // Controls packed as {PC,FD,DE,flush,EM,MW,req}
    function automatic logic [6:0] ctl();
        return {PC_WE, FD_WE, DE_WE, DE_flush, EM_WE, MW_WE, req};
    endfunction

    task automatic test_reset();
        idle_inputs();
        reset      = 1'b1;
        D_hz_stall = 1'b1;
        M_exc_req  = 1'b1;
        #1;
        checks++;
        if (ctl() !== 7'b1110110) begin
            errors++; $display("FAIL reset_ctl got %b exp %b", ctl(), 7'b1110110);
        end
        tick();
        tick();
        checks++;
        if (md_busy !== 1'b0 || md_cnt !== 4'd0 || stall_cnt !== 32'd0) begin
            errors++; $display("FAIL reset_state got busy=%b cnt=%0d stall=%0d exp 0/0/0", md_busy, md_cnt, stall_cnt);
        end
        reset = 1'b0;
        idle_inputs();
        #1;
        checks++;
        if (ctl() !== 7'b1110110) begin
            errors++; $display("FAIL idle_ctl got %b exp %b", ctl(), 7'b1110110);
        end
    endtask

    task automatic test_mult_busy();
        do_reset();
        E_md_start = 1'b1;
        tick();
        E_md_start = 1'b0;
        checks++;
        if (md_cnt !== 4'd5 || md_busy !== 1'b1) begin
            errors++; $display("FAIL mult_start got cnt=%0d busy=%b exp 5/1", md_cnt, md_busy);
        end
        for (int i = 2; i <= 5; i++) begin
            tick();
            checks++;
            if (md_cnt !== 4'(6 - i) || md_busy !== 1'b1) begin
                errors++; $display("FAIL mult_count step %0d got cnt=%0d busy=%b exp %0d/1", i, md_cnt, md_busy, 6 - i);
            end
        end
        tick();
        checks++;
        if (md_cnt !== 4'd0 || md_busy !== 1'b0) begin
            errors++; $display("FAIL mult_done got cnt=%0d busy=%b exp 0/0", md_cnt, md_busy);
        end
        checks++;
        if (stall_cnt !== 32'd0) begin
            errors++; $display("FAIL mult_nostall got %0d exp 0", stall_cnt);
        end
    endtask

    task automatic test_div_stall();
        do_reset();
        D_is_md     = 1'b1;
        E_md_start  = 1'b1;
        E_md_is_div = 1'b1;
        #1;
        checks++;
        if (ctl() !== 7'b0011110) begin
            errors++; $display("FAIL div_stall_t0 got %b exp %b", ctl(), 7'b0011110);
        end
        tick();
        E_md_start = 1'b0;
        checks++;
        if (md_cnt !== 4'd10) begin
            errors++; $display("FAIL div_load got %0d exp 10", md_cnt);
        end
        for (int i = 1; i <= 10; i++) begin
            checks++;
            if (ctl() !== 7'b0011110) begin
                errors++; $display("FAIL div_stall t+%0d got %b exp %b", i, ctl(), 7'b0011110);
            end
            tick();
        end
        checks++;
        if (stall_cnt !== 32'd11 || md_busy !== 1'b0) begin
            errors++; $display("FAIL div_total got stall=%0d busy=%b exp 11/0", stall_cnt, md_busy);
        end
        checks++;
        if (ctl() !== 7'b1110110) begin
            errors++; $display("FAIL div_release got %b exp %b", ctl(), 7'b1110110);
        end
        D_is_md = 1'b0;
    endtask

    task automatic test_exc_kills_start();
        do_reset();
        E_md_start = 1'b1;
        M_exc_req  = 1'b1;
        D_is_md    = 1'b1;
        #1;
        checks++;
        if (ctl() !== 7'b1110111) begin
            errors++; $display("FAIL exc_start_ctl got %b exp %b", ctl(), 7'b1110111);
        end
        tick();
        idle_inputs();
        checks++;
        if (md_cnt !== 4'd0 || md_busy !== 1'b0 || stall_cnt !== 32'd0) begin
            errors++; $display("FAIL exc_start_state got cnt=%0d busy=%b stall=%0d exp 0/0/0", md_cnt, md_busy, stall_cnt);
        end
    endtask

    task automatic test_hz_exc();
        do_reset();
        D_hz_stall = 1'b1;
        M_exc_req  = 1'b1;
        #1;
        checks++;
        if (req !== 1'b1 || PC_WE !== 1'b1 || DE_flush !== 1'b0) begin
            errors++; $display("FAIL hz_exc_ctl got req=%b pc=%b flush=%b exp 1/1/0", req, PC_WE, DE_flush);
        end
        tick();
        checks++;
        if (stall_cnt !== 32'd0) begin
            errors++; $display("FAIL hz_exc_count got %0d exp 0", stall_cnt);
        end
        M_exc_req = 1'b0;
        #1;
        checks++;
        if (ctl() !== 7'b0011110) begin
            errors++; $display("FAIL hz_only_ctl got %b exp %b", ctl(), 7'b0011110);
        end
        tick();
        idle_inputs();
        checks++;
        if (stall_cnt !== 32'd1) begin
            errors++; $display("FAIL hz_only_count got %0d exp 1", stall_cnt);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        // Mult start with a concurrent data hazard: one stall per cycle, not two
        E_md_start = 1'b1;
        D_is_md    = 1'b1;
        D_hz_stall = 1'b1;
        tick();
        E_md_start = 1'b0;
        D_hz_stall = 1'b0;
        checks++;
        if (stall_cnt !== 32'd1) begin
            errors++; $display("FAIL overlap_once got %0d exp 1", stall_cnt);
        end
        // Stray start while busy must not reload; exception during busy keeps counting
        E_md_start  = 1'b1;
        E_md_is_div = 1'b1;
        tick();
        E_md_start = 1'b0;
        checks++;
        if (md_cnt !== 4'd4) begin
            errors++; $display("FAIL busy_no_reload got %0d exp 4", md_cnt);
        end
        M_exc_req = 1'b1;
        #1;
        checks++;
        if (ctl() !== 7'b1110111) begin
            errors++; $display("FAIL busy_exc_ctl got %b exp %b", ctl(), 7'b1110111);
        end
        tick();
        M_exc_req = 1'b0;
        checks++;
        if (md_cnt !== 4'd3 || stall_cnt !== 32'd2) begin
            errors++; $display("FAIL busy_exc_count got cnt=%0d stall=%0d exp 3/2", md_cnt, stall_cnt);
        end
        // Reset mid-busy clears the MDU and frees the pipe
        reset = 1'b1;
        #1;
        checks++;
        if (PC_WE !== 1'b1 || DE_flush !== 1'b0) begin
            errors++; $display("FAIL rst_busy_ctl got pc=%b flush=%b exp 1/0", PC_WE, DE_flush);
        end
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (md_cnt !== 4'd0 || md_busy !== 1'b0 || stall_cnt !== 32'd0 || PC_WE !== 1'b1) begin
            errors++; $display("FAIL rst_busy_state got cnt=%0d busy=%b stall=%0d pc=%b exp 0/0/0/1", md_cnt, md_busy, stall_cnt, PC_WE);
        end
        idle_inputs();
    endtask

    task automatic test_wrap();
        do_reset();
        w_hz = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
        end
        checks++;
        if (w_stall_cnt !== 4'hF) begin
            errors++; $display("FAIL wrap_full got %0h exp f", w_stall_cnt);
        end
        tick();
        w_hz = 1'b0;
        checks++;
        if (w_stall_cnt !== 4'h0) begin
            errors++; $display("FAIL wrap_zero got %0h exp 0", w_stall_cnt);
        end
        tick();
        checks++;
        if (w_stall_cnt !== 4'h0) begin
            errors++; $display("FAIL wrap_hold got %0h exp 0", w_stall_cnt);
        end
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        test_reset();
        test_mult_busy();
        test_div_stall();
        test_exc_kills_start();
        test_hz_exc();
        test_back_to_back();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
